reg_bank_8x6: RTL

//  8-entry x WIDTH-bit general register bank; sits directly downstream of the 3-to-8

---
 rtl/reg_bank_8x6_if.sv | 31 +++
 rtl/reg_bank_8x6.sv | 91 +++++++++
 2 files changed

// File: rtl/reg_bank_8x6_if.sv
// reg_bank_8x6 bus: one-hot write strobe, dual read ports and status.
// Master drives the requests; slave is the register bank itself.
interface reg_bank_8x6_if #(
  parameter int WIDTH = 6
);
  logic [7:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [2:0]       rd_a_addr;
  logic [2:0]       rd_b_addr;
  logic             err_clr;
  logic [WIDTH-1:0] rd_a_data;
  logic [WIDTH-1:0] rd_b_data;
  logic             wr_ack;
  logic [2:0]       wr_idx;
  logic             onehot_err;

  modport master (
    output wr_sel, wr_data, rd_en,
    output rd_a_addr, rd_b_addr, err_clr,
    input  rd_a_data, rd_b_data,
    input  wr_ack, wr_idx, onehot_err
  );

  modport slave (
    input  wr_sel, wr_data, rd_en,
    input  rd_a_addr, rd_b_addr, err_clr,
    output rd_a_data, rd_b_data,
    output wr_ack, wr_idx, onehot_err
  );
endinterface

// File: rtl/reg_bank_8x6.sv
// 8-entry register bank, one-hot write, two registered read ports
// with write-through bypass and sticky illegal-select status.
module reg_bank_8x6 #(
  parameter int WIDTH   = 6,
  parameter bit R0_ZERO = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  reg_bank_8x6_if.slave bus
);

  logic [WIDTH-1:0] rf [8];
  logic [WIDTH-1:0] rd_a_q;
  logic [WIDTH-1:0] rd_b_q;
  logic             ack_q;
  logic [2:0]       idx_q;
  logic             err_q;

  logic             multi;
  logic             onehot;
  logic             accept;
  logic [2:0]       idx;
  logic [WIDTH-1:0] rd_a_nx;
  logic [WIDTH-1:0] rd_b_nx;

  // clearing the lowest set bit leaves something only if >=2 bits set
  assign multi  = (bus.wr_sel & (bus.wr_sel - 8'd1)) != 8'd0;
  assign onehot = (bus.wr_sel != 8'd0) && !multi;
  assign accept = onehot && !(R0_ZERO && bus.wr_sel[0]);

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.wr_sel[i]) idx = 3'(i);
    end
  end

  function automatic logic [WIDTH-1:0] post_val(
    input logic [2:0] a
  );
    logic [WIDTH-1:0] v;
    v = rf[a];
    if (accept && idx == a) v = bus.wr_data;
    if (R0_ZERO && a == 3'd0) v = '0;
    return v;
  endfunction

  always_comb begin
    rd_a_nx = post_val(bus.rd_a_addr);
    rd_b_nx = post_val(bus.rd_b_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (accept) begin
      rf[idx] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else if (bus.rd_en) begin
      rd_a_q <= rd_a_nx;
      rd_b_q <= rd_b_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      idx_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      ack_q <= accept;
      if (accept) idx_q <= idx;
      // a new illegal pattern outranks a clear on the same edge
      if (multi)             err_q <= 1'b1;
      else if (bus.err_clr)  err_q <= 1'b0;
    end
  end

  assign bus.rd_a_data  = rd_a_q;
  assign bus.rd_b_data  = rd_b_q;
  assign bus.wr_ack     = ack_q;
  assign bus.wr_idx     = idx_q;
  assign bus.onehot_err = err_q;

endmodule
